// File: rtl/ser_arbiter.sv
// ser_arbiter: round-robin arbiter that forwards one requester word at a time
// to a downstream serializer.
//
// Flow: IDLE picks a winner and issues a registered strobe, ack and grant id
// together. WAIT_START waits for the serializer to raise busy. WAIT_DONE waits
// for busy to fall again.
// If busy never rises, a short timeout pulses err_o and the FSM goes back to
// IDLE.
//
// Optional feature: define SER_ARBITER_STATS_EN to add per-requester 16-bit
// saturating grant counters on grant_cnt_o.
module ser_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
) (
  input  logic                      clk_i,
  input  logic                      srst_n_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic [DATA_W-1:0]         ser_data_o,
  output logic                      ser_data_val_o,
  input  logic                      ser_busy_i,
  output logic [$clog2(N_REQ)-1:0]  grant_id_o,
  output logic                      err_o
`ifdef SER_ARBITER_STATS_EN
  ,
  output logic [N_REQ*16-1:0]       grant_cnt_o
`endif
);

  localparam int ID_W = $clog2(N_REQ);

  // WAIT_START gives up once busy has stayed low on this many consecutive
  // edges. The edge that issues the strobe is not counted, so err_o appears
  // three cycles after the strobe.
  localparam logic [1:0] START_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [DATA_W-1:0]    ser_data_q, ser_data_d;
  logic                 ser_val_q, ser_val_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 err_q, err_d;
  logic [1:0]           timeout_q, timeout_d;

  // Round-robin selection results.
  logic                 found;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      cand_id;
  logic                 grant_en;

  // Unpacked view of the requester words, so a word can be picked by index.
  logic [DATA_W-1:0]    word_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign word_arr[gi] = data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin scan from last_grant+1 (mod N_REQ) upward.
  // The first active request found is the winner, so the last winner ends up
  // with the lowest priority.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand_id = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_id = ID_W'((int'(last_grant_q) + i) % N_REQ);
      if (!found && req_i[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
  end

  // A grant may only start from IDLE while the serializer is free.
  assign grant_en = (state_q == IDLE) && !ser_busy_i && found;

  // Next-state and registered-output logic.
  // The strobe, ack and err pulses default to 0, so each one lasts a single
  // cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    ser_data_d   = ser_data_q;
    ser_val_d    = 1'b0;
    ack_d        = '0;
    err_d        = 1'b0;
    timeout_d    = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          ser_data_d    = word_arr[winner];
          ser_val_d     = 1'b1;
          ack_d[winner] = 1'b1;
          grant_id_d    = winner;
          last_grant_d  = winner;
          timeout_d     = '0;
          state_d       = WAIT_START;
        end
      end

      WAIT_START: begin
        if (ser_busy_i) begin
          state_d = WAIT_DONE;
        end else if (timeout_q == START_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timeout_d = timeout_q + 2'd1;
        end
      end

      WAIT_DONE: begin
        if (!ser_busy_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  // Reset clears every output and any pending pulse. Reset also makes
  // requester 0 the first in line after release.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      grant_id_q   <= '0;
      ser_data_q   <= '0;
      ser_val_q    <= 1'b0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      timeout_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      ser_data_q   <= ser_data_d;
      ser_val_q    <= ser_val_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ack_o          = ack_q;
  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign grant_id_o     = grant_id_q;
  assign err_o          = err_q;

`ifdef SER_ARBITER_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
      logic [15:0] cnt_q, cnt_d;

      // Count grants to this requester, saturating at 0xFFFF.
      // The count advances on the same edge that raises the ack.
      always_comb begin
        cnt_d = cnt_q;
        if (grant_en && (winner == ID_W'(gi)) && (cnt_q != 16'hFFFF)) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Counter register, cleared by reset.
      always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign grant_cnt_o[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: doc/ser_arbiter.md
SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: DATA_W, 16, word width forwarded to the serializer.
REQ-003 Port: clk_i  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Port: srst_n_i  input  1  reset; synchronous, active-low.
REQ-005 Port: req_i  input  N_REQ  per-requester request; SHALL be held high with stable data until acked.
REQ-006 Port: data_i  input  N_REQ*DATA_W  requester words; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-007 Port: ack_o  output  N_REQ  one-hot, one-cycle pulse: word of requester k accepted.
REQ-008 Port: ser_data_o  output  DATA_W  word to serializer.
REQ-009 Port: ser_data_val_o  output  1  one-cycle strobe qualifying ser_data_o.
REQ-010 Port: ser_busy_i  input  1  serializer busy, high while shifting a word.
REQ-011 Port: grant_id_o  output  clog2(N_REQ)  index of the last granted requester, held until the next grant.
REQ-012 Port: err_o  output  1  one-cycle pulse on serializer start timeout.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT_START, WAIT_DONE.
REQ-014 In IDLE with ser_busy_i=0 and req_i!=0, the block SHALL select a winner by round-robin, scanning from index (last_grant+1) mod N_REQ upward.
REQ-015 On the cycle after selection, the block SHALL assert ser_data_val_o=1, ser_data_o=data_i[winner], ack_o[winner]=1 and grant_id_o=winner, update last_grant, and enter WAIT_START (grant latency 1 cycle).
REQ-016 In IDLE with ser_busy_i=1 or req_i=0, no grant SHALL be issued.
REQ-017 In WAIT_START, ser_busy_i=1 SHALL move the FSM to WAIT_DONE; if ser_busy_i stays 0 for 2 cycles, the FSM SHALL pulse err_o for 1 cycle and return to IDLE.
REQ-018 In WAIT_DONE, ser_busy_i=0 SHALL return the FSM to IDLE; the next grant issues no earlier than 1 cycle later.
REQ-019 req_i changes outside IDLE SHALL be ignored; a requester holding req_i high after its ack SHALL be treated as a new request at lowest priority.
REQ-020 ser_data_o SHALL be registered and hold its value between strobes.
REQ-021 At most one ack_o bit and one ser_data_val_o strobe SHALL occur per grant, with both in the same cycle.

Reset
REQ-022 With srst_n_i=0 at a clock edge, the FSM SHALL enter IDLE and all outputs SHALL become 0; last_grant SHALL become N_REQ-1, so requester 0 has top priority.
REQ-023 Reset asserted mid-operation SHALL abort immediately, with no pending strobe or ack emitted afterwards.
REQ-024 The first grant after reset release SHALL occur no earlier than 1 cycle after srst_n_i returns high.

Configuration
REQ-025 Macro SER_ARBITER_STATS_EN defined: an output grant_cnt_o (N_REQ*16) SHALL exist; the 16-bit counter of requester k SHALL increment on each ack_o[k], saturate at 0xFFFF, and clear on reset.
REQ-026 Macro SER_ARBITER_STATS_EN undefined: grant_cnt_o and its counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Single request: req_i=4'b0100, data word 2=16'hA5C3, busy model 16 cycles -> one strobe with ser_data_o=16'hA5C3, ack_o=4'b0100, grant_id_o=2, then no strobe until busy falls.
REQ-028 All requesting: req_i=4'b1111 held continuously after reset -> grant order 0,1,2,3,0, each grant separated by the busy period.
REQ-029 Busy at request: ser_busy_i=1 externally when req_i=4'b0001 rises -> no grant until 1 cycle after busy falls.
REQ-030 Timeout: serializer model never asserts busy -> err_o pulses 3 cycles after the strobe; the next pending request is granted afterwards.
REQ-031 Reset mid-operation: srst_n_i=0 during WAIT_DONE -> all outputs 0 next cycle; after release, req_i=4'b1010 grants requester 1 first.
REQ-032 With SER_ARBITER_STATS_EN defined: 5 grants to requester 3 -> grant_cnt_o[3*16 +: 16]=5 and all other counters 0.
